// File: rtl/codec_config_sequencer.sv
// codec_config_sequencer: walks a codec register ROM, one I2C write per word.
// Optional autostart after reset when CODEC_CFG_AUTOSTART_EN is defined.
module codec_config_sequencer #(
   parameter logic [6:0] DEV_ADDR    = 7'h1A,
   parameter int         NUM_REGS    = 11,
   parameter int         MAX_RETRIES = 3,
   parameter int         INIT_DELAY  = 1000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic       i2c_ready,
   input  logic       i2c_error,
   output logic       i2c_start_transaction,
   output logic       i2c_start_write,
   output logic       i2c_end_transaction,
   output logic       i2c_start_read,
   output logic [7:0] i2c_data_out,
   output logic       busy,
   output logic       done,
   output logic       fail,
   output logic [3:0] reg_index
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_GUARD = 3'd3;
   localparam logic [2:0] S_CHECK = 3'd4;
   localparam logic [2:0] S_NEXT  = 3'd5;

   localparam logic [2:0] P_START = 3'd0;
   localparam logic [2:0] P_ADDR  = 3'd1;
   localparam logic [2:0] P_HI    = 3'd2;
   localparam logic [2:0] P_LO    = 3'd3;
   localparam logic [2:0] P_STOP  = 3'd4;
   localparam logic [2:0] P_ABORT = 3'd5;

   localparam logic [3:0] LAST_IDX  = 4'(NUM_REGS - 1);
   localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRIES);
   localparam logic [7:0] ADDR_BYTE = {DEV_ADDR, 1'b0};

   logic [2:0]  state;
   logic [2:0]  phase;
   logic        guard_cnt;
   logic        pending;
   logic        err_q;
   logic [7:0]  retry_cnt;
   logic [15:0] word;
   logic        go;
   logic        auto_go;

   function automatic logic [15:0] rom(input logic [3:0] idx);
      case (idx)
         4'd0:    rom = {7'h0F, 9'h000};
         4'd1:    rom = {7'h00, 9'h017};
         4'd2:    rom = {7'h01, 9'h017};
         4'd3:    rom = {7'h02, 9'h079};
         4'd4:    rom = {7'h03, 9'h079};
         4'd5:    rom = {7'h04, 9'h012};
         4'd6:    rom = {7'h05, 9'h000};
         4'd7:    rom = {7'h06, 9'h000};
         4'd8:    rom = {7'h07, 9'h042};
         4'd9:    rom = {7'h08, 9'h000};
         4'd10:   rom = {7'h09, 9'h001};
         default: rom = 16'h0000;
      endcase
   endfunction

   // current ROM word; HI byte is {reg, data[8]}, LO byte is data[7:0]
   always_comb begin
      word = rom(reg_index);
   end

`ifdef CODEC_CFG_AUTOSTART_EN
   localparam logic [15:0] DLY_LAST = 16'(INIT_DELAY - 1);

   logic [15:0] dly_cnt;
   logic        armed;

   // hold off the first run until the codec has settled after reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dly_cnt <= '0;
         armed   <= 1'b1;
      end else if (armed) begin
         if (dly_cnt == DLY_LAST || state != S_IDLE) begin
            armed <= 1'b0;
         end else begin
            dly_cnt <= dly_cnt + 16'd1;
         end
      end
   end

   assign auto_go = armed && (dly_cnt == DLY_LAST);
`else
   assign auto_go = 1'b0;
`endif

   assign go             = start | auto_go;
   assign i2c_start_read = 1'b0;

   // sequencer: one command per ISSUE, wait for the master, then decide
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state                 <= S_IDLE;
         phase                 <= P_START;
         guard_cnt             <= 1'b0;
         pending               <= 1'b0;
         err_q                 <= 1'b0;
         retry_cnt             <= '0;
         reg_index             <= '0;
         busy                  <= 1'b0;
         done                  <= 1'b0;
         fail                  <= 1'b0;
         i2c_start_transaction <= 1'b0;
         i2c_start_write       <= 1'b0;
         i2c_end_transaction   <= 1'b0;
         i2c_data_out          <= '0;
      end else begin
         i2c_start_transaction <= 1'b0;
         i2c_start_write       <= 1'b0;
         i2c_end_transaction   <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (go) begin
                  done      <= 1'b0;
                  fail      <= 1'b0;
                  reg_index <= '0;
                  retry_cnt <= '0;
                  busy      <= 1'b1;
                  phase     <= P_START;
                  pending   <= 1'b0;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i2c_ready) begin
                  err_q <= i2c_error;
                  state <= pending ? S_CHECK : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (i2c_ready) begin
                  case (phase)
                     P_START: i2c_start_transaction <= 1'b1;
                     P_ADDR: begin
                        i2c_start_write <= 1'b1;
                        i2c_data_out    <= ADDR_BYTE;
                     end
                     P_HI: begin
                        i2c_start_write <= 1'b1;
                        i2c_data_out    <= word[15:8];
                     end
                     P_LO: begin
                        i2c_start_write <= 1'b1;
                        i2c_data_out    <= word[7:0];
                     end
                     default: i2c_end_transaction <= 1'b1;
                  endcase
                  guard_cnt <= 1'b0;
                  pending   <= 1'b1;
                  state     <= S_GUARD;
               end
            end
            S_GUARD: begin
               guard_cnt <= 1'b1;
               if (guard_cnt) begin
                  state <= S_WAIT;
               end
            end
            S_CHECK: begin
               pending <= 1'b0;
               state   <= S_ISSUE;
               case (phase)
                  P_START: phase <= P_ADDR;
                  P_ADDR, P_HI, P_LO: begin
                     phase <= err_q ? P_ABORT : phase + 3'd1;
                  end
                  P_STOP: state <= S_NEXT;
                  default: begin
                     retry_cnt <= retry_cnt + 8'd1;
                     if (retry_cnt < RETRY_MAX) begin
                        phase <= P_START;
                     end else begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                     end
                  end
               endcase
            end
            S_NEXT: begin
               retry_cnt <= '0;
               if (reg_index == LAST_IDX) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  reg_index <= reg_index + 4'd1;
                  phase     <= P_START;
                  state     <= S_ISSUE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
